// File: rtl/log_spawn_ctrl.sv
// rtl/log_spawn_ctrl.sv - log slot spawn scheduler: 5 lanes x 3 slots, frame-paced per-lane spawning
module log_spawn_ctrl #(
    parameter logic [8:0] LANE_Y0    = 9'd64,
    parameter logic [8:0] LANE_PITCH = 9'd40,
    parameter logic [8:0] X_RIGHT    = 9'd480,
    parameter logic [5:0] MIN_GAP    = 6'd12
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        start,
    input  logic        startOfFrame,
    input  logic        timer_done,
    input  logic [1:0]  level,
    input  logic [3:0]  random_0_15,
    input  logic [14:0] despawn,
    output logic [14:0] enable,
    output logic [8:0]  start_offsetY [15],
    output logic [8:0]  start_offsetX [15],
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SCAN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  lane_q, lane_d;
    logic [5:0]  cnt_q [5];
    logic [5:0]  cnt_d [5];
    logic [5:0]  tgt_q [5];
    logic [5:0]  tgt_d [5];
    logic [14:0] en_q, en_d;
    logic [8:0]  offx_q [15];
    logic [8:0]  offx_d [15];
    logic [8:0]  offy_q [15];
    logic [8:0]  offy_d [15];
    logic        busy_q;

    logic [3:0]  base;
    logic [3:0]  slot;
    logic [1:0]  pick;
    logic        found;
    logic [5:0]  cnt_inc;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        offx_d  = offx_q;
        offy_d  = offy_q;
        en_d    = en_q & ~despawn;
        base    = 4'({1'b0, lane_q} * 4'd3);
        found   = 1'b0;
        pick    = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!found && !en_q[base + 4'(k)]) begin
                found = 1'b1;
                pick  = 2'(k);
            end
        end
        slot    = base + {2'b00, pick};
        cnt_inc = (cnt_q[lane_q] == 6'd63) ? 6'd63 : cnt_q[lane_q] + 6'd1;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (timer_done) begin
                    state_d = S_DONE;
                end else if (startOfFrame) begin
                    state_d = S_SCAN;
                    lane_d  = 3'd0;
                end
            end
            S_SCAN: begin
                cnt_d[lane_q] = cnt_inc;
                // A same-cycle despawn on the chosen slot suppresses the spawn entirely
                if (cnt_inc >= tgt_q[lane_q] && found && !despawn[slot]) begin
                    en_d[slot]    = 1'b1;
                    offx_d[slot]  = lane_q[0] ? X_RIGHT : 9'd0;
                    offy_d[slot]  = LANE_Y0 + {6'd0, lane_q} * LANE_PITCH;
                    cnt_d[lane_q] = 6'd0;
                    tgt_d[lane_q] = MIN_GAP + ({2'b00, random_0_15} >> level);
                end
                if (lane_q == 3'd4) begin
                    state_d = timer_done ? S_DONE : S_WAIT;
                end else begin
                    lane_d = lane_q + 3'd1;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_WAIT;
                    for (int l = 0; l < 5; l++) cnt_d[l] = 6'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= S_IDLE;
            lane_q  <= 3'd0;
            en_q    <= 15'd0;
            busy_q  <= 1'b0;
            for (int l = 0; l < 5; l++) begin
                cnt_q[l] <= 6'd0;
                tgt_q[l] <= MIN_GAP;
            end
            for (int s = 0; s < 15; s++) begin
                offx_q[s] <= 9'd0;
                offy_q[s] <= 9'd0;
            end
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            en_q    <= en_d;
            busy_q  <= (state_d == S_SCAN);
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            offx_q  <= offx_d;
            offy_q  <= offy_d;
        end
    end

    assign enable        = en_q;
    assign busy          = busy_q;
    assign start_offsetX = offx_q;
    assign start_offsetY = offy_q;

endmodule

// File: tb/tb_log_spawn_ctrl.sv
// tb/tb_log_spawn_ctrl.sv - directed, table-driven bench for log_spawn_ctrl
module tb_log_spawn_ctrl;

    logic        CLK;
    logic        RESETn;
    logic        start;
    logic        startOfFrame;
    logic        timer_done;
    logic [1:0]  level;
    logic [3:0]  random_0_15;
    logic [14:0] despawn;
    logic [14:0] enable;
    logic [8:0]  start_offsetY [15];
    logic [8:0]  start_offsetX [15];
    logic        busy;

    int checks;
    int failures;

    typedef struct {
        logic       en;
        logic [8:0] x;
        logic [8:0] y;
    } slot_vec_t;

    slot_vec_t tbl [15];

    log_spawn_ctrl dut (
        .CLK          (CLK),
        .RESETn       (RESETn),
        .start        (start),
        .startOfFrame (startOfFrame),
        .timer_done   (timer_done),
        .level        (level),
        .random_0_15  (random_0_15),
        .despawn      (despawn),
        .enable       (enable),
        .start_offsetY(start_offsetY),
        .start_offsetX(start_offsetX),
        .busy         (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (5) tick();
    endtask

    task automatic pulse_despawn(input logic [14:0] m);
        despawn = m;
        tick();
        despawn = 15'd0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_offsets_zero(input string name);
        for (int s = 0; s < 15; s++) begin
            chk($sformatf("%s_x%0d", name, s), 32'(start_offsetX[s]), 32'd0);
            chk($sformatf("%s_y%0d", name, s), 32'(start_offsetY[s]), 32'd0);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        RESETn       = 1'b0;
        start        = 1'b0;
        startOfFrame = 1'b0;
        timer_done   = 1'b0;
        level        = 2'd0;
        random_0_15  = 4'd0;
        despawn      = 15'd0;

        // Expected slot state after the first spawn round (level 0, random 0)
        for (int s = 0; s < 15; s++) tbl[s] = '{1'b0, 9'd0, 9'd0};
        tbl[0]  = '{1'b1, 9'd0,   9'd64};
        tbl[3]  = '{1'b1, 9'd480, 9'd104};
        tbl[6]  = '{1'b1, 9'd0,   9'd144};
        tbl[9]  = '{1'b1, 9'd480, 9'd184};
        tbl[12] = '{1'b1, 9'd0,   9'd224};

        // T1: reset state, then no start for 100 frames
        repeat (3) tick();
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk_offsets_zero("rst");
        RESETn = 1'b1;
        tick();
        repeat (100) frame();
        chk("idle_enable", 32'(enable), 32'd0);

        // T2: first spawn after 12 frames
        pulse_start();
        repeat (11) frame();
        chk("pre_spawn_enable", 32'(enable), 32'd0);
        frame();
        chk("first_spawn_enable", 32'(enable), 32'h1249);
        for (int s = 0; s < 15; s++) begin
            chk($sformatf("t2_en%0d", s), 32'(enable[s]), 32'(tbl[s].en));
            chk($sformatf("t2_x%0d", s), 32'(start_offsetX[s]), 32'(tbl[s].x));
            chk($sformatf("t2_y%0d", s), 32'(start_offsetY[s]), 32'(tbl[s].y));
        end

        // T3: lanes fill up, then saturate; a freed slot respawns next frame
        repeat (12) frame();
        chk("second_round", 32'(enable), 32'h36DB);
        repeat (12) frame();
        chk("lanes_full", 32'(enable), 32'h7FFF);
        repeat (70) frame();
        chk("full_hold", 32'(enable), 32'h7FFF);
        pulse_despawn(15'h0010);
        chk("despawn4", 32'(enable), 32'h7FEF);
        frame();
        chk("respawn4", 32'(enable), 32'h7FFF);
        chk("respawn4_x", 32'(start_offsetX[4]), 32'd480);
        chk("respawn4_y", 32'(start_offsetY[4]), 32'd104);

        // T4: despawn collides with lane 0 spawn into slot 1
        pulse_despawn(15'h0002);
        chk("free_slot1", 32'(enable), 32'h7FFD);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        despawn = 15'h0002;
        tick();
        despawn = 15'd0;
        chk("collision_en1", 32'(enable[1]), 32'd0);
        chk("collision_busy", 32'(busy), 32'd1);
        repeat (4) tick();
        chk("collision_after_scan", 32'(enable), 32'h7FFD);
        chk("collision_idle_busy", 32'(busy), 32'd0);
        frame();
        chk("collision_retry", 32'(enable), 32'h7FFF);

        // T5: timer expires mid-scan; scan completes, then no spawns until restart
        pulse_despawn(15'h01C0);
        chk("free_lane2", 32'(enable), 32'h7E3F);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        timer_done = 1'b1;
        repeat (5) tick();
        chk("timer_scan_done", 32'(enable), 32'h7E7F);
        chk("timer_busy", 32'(busy), 32'd0);
        repeat (20) frame();
        chk("done_no_spawn", 32'(enable), 32'h7E7F);
        pulse_despawn(15'h0001);
        chk("done_despawn", 32'(enable), 32'h7E7E);
        timer_done = 1'b0;
        repeat (3) frame();
        chk("done_stays", 32'(enable), 32'h7E7E);
        pulse_start();
        repeat (11) frame();
        chk("restart_gap", 32'(enable), 32'h7E7E);
        frame();
        chk("restart_spawn", 32'(enable), 32'h7EFF);
        chk("restart_x7", 32'(start_offsetX[7]), 32'd0);
        chk("restart_y7", 32'(start_offsetY[7]), 32'd144);

        // T6: asynchronous reset in the middle of a scan
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        chk("mid_scan_busy", 32'(busy), 32'd1);
        #2;
        RESETn = 1'b0;
        #1;
        chk("async_enable", 32'(enable), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk_offsets_zero("async");
        tick();
        RESETn = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
